// File: rtl/image_pkg.sv
// Shared definitions for the image coprocessor's quadrant walkers (reader and control-unit writer).
package image_pkg;
  localparam int ADDR_W   = 17;
  localparam int PIX_W    = 8;
  localparam int DIM_W    = 9;
  localparam int QUAD_DIM = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;
endpackage

// File: rtl/quadrant_scan_counter.sv
// Walks px, then py, then qx, then qy; shared by the reader and writer so both use one pixel order.
module quadrant_scan_counter #(
  parameter int DIM_W    = image_pkg::DIM_W,
  parameter int QUAD_DIM = image_pkg::QUAD_DIM,
  localparam int P_W     = $clog2(QUAD_DIM),
  localparam int Q_W     = DIM_W - P_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear_i,
  input  logic           step_i,
  input  logic [Q_W-1:0] qw_i,
  input  logic [Q_W-1:0] qh_i,
  output logic [P_W-1:0] px_o,
  output logic [P_W-1:0] py_o,
  output logic [Q_W-1:0] qx_o,
  output logic [Q_W-1:0] qy_o,
  output logic           last_o
);
  localparam logic [P_W-1:0] P_MAX = P_W'(QUAD_DIM - 1);

  logic [P_W-1:0] px_q, px_d, py_q, py_d;
  logic [Q_W-1:0] qx_q, qx_d, qy_q, qy_d;
  logic           qx_max, qy_max;

  assign qx_max = (qx_q == qw_i - Q_W'(1));
  assign qy_max = (qy_q == qh_i - Q_W'(1));

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    qx_d = qx_q;
    qy_d = qy_q;
    if (clear_i) begin
      px_d = '0;
      py_d = '0;
      qx_d = '0;
      qy_d = '0;
    end else if (step_i) begin
      if (px_q != P_MAX) begin
        px_d = px_q + P_W'(1);
      end else begin
        px_d = '0;
        if (py_q != P_MAX) begin
          py_d = py_q + P_W'(1);
        end else begin
          py_d = '0;
          if (!qx_max) begin
            qx_d = qx_q + Q_W'(1);
          end else begin
            qx_d = '0;
            qy_d = qy_max ? '0 : qy_q + Q_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q <= '0;
      py_q <= '0;
      qx_q <= '0;
      qy_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
      qx_q <= qx_d;
      qy_q <= qy_d;
    end
  end

  assign px_o   = px_q;
  assign py_o   = py_q;
  assign qx_o   = qx_q;
  assign qy_o   = qy_q;
  assign last_o = (px_q == P_MAX) && (py_q == P_MAX) && qx_max && qy_max;
endmodule

// File: rtl/image_quadrant_reader.sv
// Reads pixel memory quadrant by quadrant and streams each pixel out with quadrant tag and last flag.
module image_quadrant_reader #(
  parameter int ADDR_W   = image_pkg::ADDR_W,
  parameter int PIX_W    = image_pkg::PIX_W,
  parameter int DIM_W    = image_pkg::DIM_W,
  parameter int QUAD_DIM = image_pkg::QUAD_DIM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  image_width,
  input  logic [DIM_W-1:0]  image_height,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic [7:0]        pix_quadrant,
  output logic              pix_last,
  output logic              busy,
  output logic              done
);
  import image_pkg::*;

  localparam int P_W    = $clog2(QUAD_DIM);
  localparam int Q_W    = DIM_W - P_W;
  localparam int A_FULL = 2 * DIM_W + 1;
  localparam int QI_W   = 2 * Q_W + 8;

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   w_q, w_d;
  logic [Q_W-1:0]     qh_q, qh_d, qw;
  logic [PIX_W-1:0]   pix_data_q, pix_data_d;
  logic [7:0]         quad_q, quad_d;
  logic               valid_q, valid_d, last_q, last_d;
  logic               scan_clear, scan_step, scan_last;
  logic [P_W-1:0]     px, py;
  logic [Q_W-1:0]     qx, qy;
  logic [A_FULL-1:0]  addr_full;
  logic [QI_W-1:0]    quad_full;
  logic               unused_bits;

  assign qw        = w_q[DIM_W-1:P_W];
  assign addr_full = A_FULL'({qy, py}) * A_FULL'(w_q) + A_FULL'({qx, px});
  assign quad_full = QI_W'(qy) * QI_W'(qw) + QI_W'(qx);
  assign unused_bits = ^{addr_full[A_FULL-1:ADDR_W], quad_full[QI_W-1:8], image_height[P_W-1:0]};

  quadrant_scan_counter #(.DIM_W(DIM_W), .QUAD_DIM(QUAD_DIM)) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (scan_clear),
    .step_i  (scan_step),
    .qw_i    (qw),
    .qh_i    (qh_q),
    .px_o    (px),
    .py_o    (py),
    .qx_o    (qx),
    .qy_o    (qy),
    .last_o  (scan_last)
  );

  // Handshake: a pixel transfers on a cycle with pix_valid && pix_ready; pix_valid never drops before that.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    qh_d       = qh_q;
    pix_data_d = pix_data_q;
    quad_d     = quad_q;
    valid_d    = valid_q;
    last_d     = last_q;
    scan_clear = 1'b0;
    scan_step  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    done       = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_d  = image_width;
          qh_d = image_height[DIM_W-1:P_W];
          if (image_width[DIM_W-1:P_W] == '0 || image_height[DIM_W-1:P_W] == '0) begin
            state_d = ST_DONE;
          end else begin
            scan_clear = 1'b1;
            state_d    = ST_READ;
          end
        end
      end
      ST_READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_full[ADDR_W-1:0];
        state_d   = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        pix_data_d = mem_rd_data;
        quad_d     = quad_full[7:0];
        last_d     = scan_last;
        valid_d    = 1'b1;
        state_d    = ST_STREAM;
      end
      ST_STREAM: begin
        if (pix_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            scan_step = 1'b1;
            state_d   = ST_READ;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      qh_q       <= '0;
      pix_data_q <= '0;
      quad_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      qh_q       <= qh_d;
      pix_data_q <= pix_data_d;
      quad_q     <= quad_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign pix_valid    = valid_q;
  assign pix_data     = pix_data_q;
  assign pix_quadrant = quad_q;
  assign pix_last     = last_q;
endmodule

// File: tb/tb_image_quadrant_reader.sv
// Bench for image_quadrant_reader: memory model, randomized runs, reference walk of the quadrant order.
module tb_image_quadrant_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  image_width = '0;
  logic [8:0]  image_height = '0;
  logic [7:0]  mem_rd_data = '0;
  logic        pix_ready = 1'b0;
  logic        mem_rd_en, pix_valid, pix_last, busy, done;
  logic [16:0] mem_addr;
  logic [7:0]  pix_data, pix_quadrant;

  logic [7:0]  mem [0:131071];
  logic [33:0] exp_q[$];
  logic [16:0] rd_addr_q[$];

  int n_compared = 0, n_mismatch = 0;
  int hs_cnt = 0, done_cnt = 0, busy_cnt = 0, rd_cnt = 0, valid_cnt = 0, viol = 0, cyc = 0;
  int first_hs_cyc = 0, last_hs_cyc = 0, run_base_hs = 0;
  int base_done = 0, base_rd = 0, base_valid = 0, base_busy = 0;
  int ready_mode = 0, stall_ctr = 0, inject_state = 0;
  bit done_expect = 0, stall_prev = 0;
  logic [7:0] prev_data, prev_quad;
  logic       prev_last;

  image_quadrant_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .image_width  (image_width),
    .image_height (image_height),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_quadrant (pix_quadrant),
    .pix_last     (pix_last),
    .busy         (busy),
    .done         (done)
  );

  // Clock and synchronous-read memory.
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completed pixel handshake.
  always @(negedge clk) begin
    logic [33:0] e;
    logic [16:0] ra;
    if (!rst_n) begin
      stall_prev = 0;
      done_expect = 0;
    end else begin
      cyc++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (done_expect) check("done_after_last", done, 1);
      done_expect = 0;
      if (mem_rd_en && pix_valid) viol++;
      if (mem_rd_en) begin
        rd_cnt++;
        rd_addr_q.push_back(mem_addr);
      end
      if (pix_valid) valid_cnt++;
      if (stall_prev && (!pix_valid || pix_data !== prev_data ||
                         pix_quadrant !== prev_quad || pix_last !== prev_last)) viol++;
      stall_prev = pix_valid && !pix_ready;
      prev_data = pix_data;
      prev_quad = pix_quadrant;
      prev_last = pix_last;
      if (pix_valid && pix_ready) begin
        if (hs_cnt == run_base_hs) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        hs_cnt++;
        if (exp_q.size() == 0 || rd_addr_q.size() == 0) begin
          n_compared++;
          n_mismatch++;
          $display("FAIL pixel: unexpected pixel %0h (quadrant %0d)", pix_data, pix_quadrant);
        end else begin
          e = exp_q.pop_front();
          ra = rd_addr_q.pop_front();
          check("pixel{addr,quad,last,data}", {ra, pix_quadrant, pix_last, pix_data}, e);
        end
        done_expect = pix_last;
      end
    end
  end

  // Downstream ready driver and the start-while-busy injector.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ($urandom_range(0, 9) < 7);
        2: if (pix_valid && (hs_cnt - run_base_hs) == 3 && stall_ctr < 5) begin
             pix_ready = 1'b0;
             stall_ctr++;
           end else pix_ready = 1'b1;
        default: pix_ready = ((hs_cnt - run_base_hs) < 9);
      endcase
      if (inject_state == 2) begin
        start = 1'b0;
        inject_state = 3;
      end else if (inject_state == 1 && (hs_cnt - run_base_hs) == 5) begin
        start = 1'b1;
        image_width = 9'd32;
        inject_state = 2;
      end
    end
  end

  // Reference: quadrant-major, row-major inside a quadrant, address = row*W + column.
  task automatic start_run(input int w, input int h, input int rmode, input bit idx_fill);
    int qw, qh, n, k, a;
    qw = w / 8;
    qh = h / 8;
    n = qw * qh * 64;
    for (int i = 0; i < w * h; i++) mem[i % 131072] = idx_fill ? 8'(i) : 8'($urandom);
    k = 0;
    for (int qy = 0; qy < qh; qy++)
      for (int qx = 0; qx < qw; qx++)
        for (int py = 0; py < 8; py++)
          for (int px = 0; px < 8; px++) begin
            a = ((qy * 8 + py) * w + qx * 8 + px) % 131072;
            exp_q.push_back({17'(a), 8'((qy * qw + qx) % 256), (k == n - 1), mem[a]});
            k++;
          end
    ready_mode = rmode;
    stall_ctr = 0;
    base_done = done_cnt;
    base_rd = rd_cnt;
    base_valid = valid_cnt;
    base_busy = busy_cnt;
    run_base_hs = hs_cnt;
    @(posedge clk);
    #1;
    image_width = 9'(w);
    image_height = 9'(h);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    image_width = 9'($urandom);
    image_height = 9'($urandom);
  endtask

  task automatic run_image(input int w, input int h, input int rmode, input bit idx_fill);
    int n, bound, cnt;
    n = (w / 8) * (h / 8) * 64;
    bound = n * 20 + 100;
    start_run(w, h, rmode, idx_fill);
    cnt = 0;
    while (done_cnt == base_done && cnt < bound) begin
      @(posedge clk);
      cnt++;
    end
    check("run_completes_in_budget", cnt < bound, 1);
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    check("done_pulses", done_cnt - base_done, 1);
    check("pixel_count", hs_cnt - run_base_hs, n);
    check("idle_after_run", busy, 0);
    exp_q.delete();
    rd_addr_q.delete();
  endtask

  initial begin
    int cnt, w, h;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {mem_rd_en, mem_addr, pix_valid, pix_data, pix_quadrant, pix_last}, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Single quadrant, identity memory, continuous ready.
    run_image(8, 8, 0, 1);
    check("throughput_3_cycles", last_hs_cyc - first_hs_cyc, 63 * 3);

    // 2x2 quadrants, random back-pressure.
    run_image(16, 16, 1, 0);

    // Five-cycle stall on pixel 3.
    run_image(8, 8, 2, 0);
    check("stall_applied", stall_ctr, 5);

    // Width below one quadrant goes straight to DONE.
    run_image(4, 16, 0, 0);
    check("degenerate_no_reads", rd_cnt - base_rd, 0);
    check("degenerate_no_valid", valid_cnt - base_valid, 0);
    check("degenerate_busy_seen", (busy_cnt - base_busy) != 0, 1);

    // Second start with a different width while busy is ignored.
    inject_state = 1;
    run_image(16, 8, 0, 0);
    check("second_start_issued", inject_state, 3);
    inject_state = 0;

    // Reset while pixel 10 waits in the output stage.
    start_run(16, 16, 3, 0);
    cnt = 0;
    do begin
      @(negedge clk);
      #1;
      cnt++;
    end while (!(pix_valid && (hs_cnt - run_base_hs) == 9) && cnt < 500);
    check("abort_point_reached", cnt < 500, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", {mem_rd_en, mem_addr, pix_valid, pix_data, pix_quadrant, pix_last}, 0);
    check("abort_busy_done", {busy, done}, 0);
    exp_q.delete();
    rd_addr_q.delete();
    ready_mode = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check("abort_no_done", done_cnt - base_done, 0);
    run_image(8, 8, 0, 1);

    // Random image sizes and back-pressure.
    for (int i = 0; i < 4; i++) begin
      w = $urandom_range(0, 40);
      h = $urandom_range(0, 40);
      run_image(w, h, 1, 0);
    end

    // 264 quadrants: pix_quadrant wraps past 255.
    run_image(64, 264, 0, 0);

    check("rd_en_valid_overlap_or_unstable_stall", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end
endmodule
